// File: rtl/mem_arbiter.sv
// Round-robin arbiter that gives the instruction cache (port 0) and the data cache (port 1)
// turns on one main-memory port. Each port moves one full cache line, one transaction at a time.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 512
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            req_valid_i,
    input  logic [2*ADDR_W-1:0]   req_addr_i,
    input  logic [1:0]            req_we_i,
    input  logic [2*LINE_W-1:0]   req_wdata_i,
    output logic [1:0]            resp_valid_o,
    output logic [LINE_W-1:0]     resp_data_o,
    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic                  mem_we_o,
    output logic [LINE_W-1:0]     mem_wdata_o,
    input  logic                  mem_resp_valid_i,
    input  logic [LINE_W-1:0]     mem_rdata_i,
    output logic                  busy_o,
    output logic                  grant_o
);

    // Clears the byte-offset-within-line bits of an address.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'((LINE_W / 8) - 1));

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic                last_grant_r;
    logic                last_grant_s;
    logic                grant_r;
    logic                grant_s;
    logic [ADDR_W-1:0]   addr_r;
    logic [ADDR_W-1:0]   addr_s;
    logic                we_r;
    logic                we_s;
    logic [LINE_W-1:0]   wdata_r;
    logic [LINE_W-1:0]   wdata_s;
    logic [LINE_W-1:0]   data_r;
    logic [LINE_W-1:0]   data_s;
    logic [1:0]          resp_valid_r;
    logic [1:0]          resp_valid_s;
    logic                mem_req_valid_r;
    logic                busy_r;
    logic                win_s;
    logic [ADDR_W-1:0]   sel_addr_s;

    // Next-state, arbitration and transaction capture.
    always_comb begin
        state_s      = state_r;
        last_grant_s = last_grant_r;
        grant_s      = grant_r;
        addr_s       = addr_r;
        we_s         = we_r;
        wdata_s      = wdata_r;
        data_s       = data_r;
        resp_valid_s = 2'b00;
        win_s        = 1'b0;
        sel_addr_s   = {ADDR_W{1'b0}};

        case (state_r)
            IDLE: begin
                if (req_valid_i != 2'b00) begin
                    // On a tie the port that did not win last time goes next.
                    if (req_valid_i == 2'b11) begin
                        win_s = ~last_grant_r;
                    end else begin
                        win_s = req_valid_i[1];
                    end
                    if (win_s) begin
                        sel_addr_s = req_addr_i[2*ADDR_W-1:ADDR_W];
                        wdata_s    = req_wdata_i[2*LINE_W-1:LINE_W];
                    end else begin
                        sel_addr_s = req_addr_i[ADDR_W-1:0];
                        wdata_s    = req_wdata_i[LINE_W-1:0];
                    end
                    addr_s  = sel_addr_s & ALIGN_MASK;
                    we_s    = req_we_i[win_s];
                    grant_s = win_s;
                    state_s = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                if (mem_req_ready_i) begin
                    last_grant_s = grant_r;
                    state_s      = WAIT;
                end else begin
                    state_s = ISSUE;
                end
            end
            WAIT: begin
                if (mem_resp_valid_i) begin
                    // A write acknowledge carries no line back to the cache.
                    if (we_r) begin
                        data_s = {LINE_W{1'b0}};
                    end else begin
                        data_s = mem_rdata_i;
                    end
                    if (grant_r) begin
                        resp_valid_s = 2'b10;
                    end else begin
                        resp_valid_s = 2'b01;
                    end
                    state_s = RESP;
                end else begin
                    state_s = WAIT;
                end
            end
            RESP: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers; outputs are derived from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r         <= IDLE;
            last_grant_r    <= 1'b0;
            grant_r         <= 1'b0;
            addr_r          <= {ADDR_W{1'b0}};
            we_r            <= 1'b0;
            wdata_r         <= {LINE_W{1'b0}};
            data_r          <= {LINE_W{1'b0}};
            resp_valid_r    <= 2'b00;
            mem_req_valid_r <= 1'b0;
            busy_r          <= 1'b0;
        end else begin
            state_r         <= state_s;
            last_grant_r    <= last_grant_s;
            grant_r         <= grant_s;
            addr_r          <= addr_s;
            we_r            <= we_s;
            wdata_r         <= wdata_s;
            data_r          <= data_s;
            resp_valid_r    <= resp_valid_s;
            mem_req_valid_r <= (state_s == ISSUE);
            busy_r          <= (state_s != IDLE);
        end
    end

    assign resp_valid_o    = resp_valid_r;
    assign resp_data_o     = data_r;
    assign mem_req_valid_o = mem_req_valid_r;
    assign mem_addr_o      = addr_r;
    assign mem_we_o        = we_r;
    assign mem_wdata_o     = wdata_r;
    assign busy_o          = busy_r;
    assign grant_o         = grant_r;

endmodule
